// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control unit: fetch/exec/writeback sequencing around an external ALU.
// Optional HACK_CTRL_HALT_EN adds a halted output that latches on a jump-to-self.
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [14:0] pc,
  input  logic [15:0] in_m,
  output logic [15:0] out_m,
  output logic        write_m,
  output logic [14:0] address_m,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_o,
  input  logic        alu_zr,
  input  logic        alu_ng
`ifdef HACK_CTRL_HALT_EN
  ,
  output logic        halted
`endif
);

  typedef enum logic [1:0] {StFetch, StExec, StWb, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] res_q, res_d;
  logic        jmp_q, jmp_d;
  logic [14:0] pc_inc;
  logic        jmp_eval;
  logic        is_c;

`ifdef HACK_CTRL_HALT_EN
  logic halted_q, halted_d;
  logic self_jump;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      ir_q    <= 16'd0;
      a_q     <= 16'd0;
      d_q     <= 16'd0;
      pc_q    <= RESET_PC;
      res_q   <= 16'd0;
      jmp_q   <= 1'b0;
`ifdef HACK_CTRL_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      res_q   <= res_d;
      jmp_q   <= jmp_d;
`ifdef HACK_CTRL_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    d_d      = d_q;
    pc_d     = pc_q;
    res_d    = res_q;
    jmp_d    = jmp_q;
    is_c     = ir_q[15];
    pc_inc   = pc_q + 15'd1;
    jmp_eval = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);
`ifdef HACK_CTRL_HALT_EN
    halted_d  = halted_q;
    // pc_q still holds the address of the instruction in WB
    self_jump = (ir_q[2:0] == 3'b111) && (a_q[14:0] == pc_q);
`endif

    unique case (state_q)
      StFetch: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = instr[15] ? StExec : StWb;
        end
      end
      StExec: begin
        res_d   = alu_o;
        jmp_d   = jmp_eval;
        state_d = StWb;
      end
      StWb: begin
        state_d = StFetch;
        if (!is_c) begin
          a_d  = {1'b0, ir_q[14:0]};
          pc_d = pc_inc;
        end else begin
          if (ir_q[4]) d_d = res_q;
          if (ir_q[5]) a_d = res_q;
          // Jump target is the A value from before this instruction's own A write
          pc_d = jmp_q ? a_q[14:0] : pc_inc;
`ifdef HACK_CTRL_HALT_EN
          if (self_jump) begin
            halted_d = 1'b1;
            state_d  = StHalt;
          end
`endif
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_comb begin
    instr_ready = rst_n && (state_q == StFetch);
    pc          = pc_q;
    address_m   = a_q[14:0];
    out_m       = res_q;
    write_m     = (state_q == StWb) && ir_q[15] && ir_q[3];
    alu_x       = d_q;
    alu_y       = ir_q[12] ? in_m : a_q;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} =
        (state_q == StExec) ? ir_q[11:6] : 6'b000000;
  end

`ifdef HACK_CTRL_HALT_EN
  assign halted = halted_q;
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed self-checking bench for hack_cpu_ctrl with a behavioural Hack ALU model.
// Exercises the HACK_CTRL_HALT_EN variant when that macro is defined.
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] pc;
  logic [15:0] in_m;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [15:0] alu_x, alu_y, alu_o;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic        alu_zr, alu_ng;
`ifdef HACK_CTRL_HALT_EN
  logic        halted;
`endif

  int n_checks;
  int n_fail;

  int          r_cyc, r_wr;
  logic [15:0] r_wdata;
  logic [14:0] r_waddr;
  logic [5:0]  r_ctl;
  logic [15:0] r_ay;

  hack_cpu_ctrl #(.RESET_PC(15'd0)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .in_m(in_m), .out_m(out_m), .write_m(write_m),
    .address_m(address_m), .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx),
    .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_o(alu_o),
    .alu_zr(alu_zr), .alu_ng(alu_ng)
`ifdef HACK_CTRL_HALT_EN
    , .halted(halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Hack ALU
  logic [15:0] mx, my, mo;
  always_comb begin
    mx = alu_zx ? 16'd0 : alu_x;
    mx = alu_nx ? ~mx : mx;
    my = alu_zy ? 16'd0 : alu_y;
    my = alu_ny ? ~my : my;
    mo = alu_f ? (mx + my) : (mx & my);
    mo = alu_no ? ~mo : mo;
    alu_o  = mo;
    alu_zr = (mo == 16'd0);
    alu_ng = mo[15];
  end

  // Issue one instruction and follow it until the block is ready again.
  task automatic run_instr(input logic [15:0] ins);
    int t;
    t = 0;
    while (!instr_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    r_cyc = 1;
    r_wr = 0;
    r_wdata = 16'hxxxx;
    r_waddr = 15'hxxxx;
    r_ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
    r_ay = alu_y;
    while (!instr_ready && r_cyc < 10) begin
      if (write_m) begin
        r_wr++;
        r_wdata = out_m;
        r_waddr = address_m;
      end
      @(posedge clk);
      #1;
      r_cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'd0;
    in_m = 16'd0;
    #2;
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", instr_ready); end
    n_checks++; if (pc !== 15'd0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_checks++; if (write_m !== 1'b0) begin n_fail++; $display("FAIL rst_write_m: got %b want 0", write_m); end
    n_checks++; if (out_m !== 16'd0) begin n_fail++; $display("FAIL rst_out_m: got %h want 0", out_m); end
    n_checks++; if (address_m !== 15'd0 || alu_x !== 16'd0) begin n_fail++; $display("FAIL rst_a_d: got A=%h D=%h want 0 0", address_m, alu_x); end
    n_checks++; if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'd0) begin n_fail++; $display("FAIL rst_ctl: got nonzero want 000000"); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", instr_ready); end
  endtask

  task automatic test_a_instr;
    run_instr(16'h0010);
    n_checks++; if (r_cyc !== 2) begin n_fail++; $display("FAIL a_latency: got %0d want 2", r_cyc); end
    n_checks++; if (r_wr !== 0) begin n_fail++; $display("FAIL a_no_write: got %0d want 0", r_wr); end
    n_checks++; if (address_m !== 15'd16) begin n_fail++; $display("FAIL a_value: got %h want 0010", address_m); end
    n_checks++; if (pc !== 15'd1) begin n_fail++; $display("FAIL a_pc: got %h want 1", pc); end
  endtask

  task automatic test_d_eq_a;
    run_instr(16'hEC10);
    n_checks++; if (r_ctl !== 6'b110000) begin n_fail++; $display("FAIL dea_ctl: got %b want 110000", r_ctl); end
    n_checks++; if (r_ay !== 16'd16) begin n_fail++; $display("FAIL dea_alu_y: got %h want 0010", r_ay); end
    n_checks++; if (r_cyc !== 3) begin n_fail++; $display("FAIL c_latency: got %0d want 3", r_cyc); end
    n_checks++; if (alu_x !== 16'd16) begin n_fail++; $display("FAIL dea_d: got %h want 0010", alu_x); end
    n_checks++; if (pc !== 15'd2) begin n_fail++; $display("FAIL dea_pc: got %h want 2", pc); end
  endtask

  task automatic test_add_store;
    run_instr(16'h000F);
    run_instr(16'hE090);
    n_checks++; if (alu_x !== 16'd31) begin n_fail++; $display("FAIL add_d: got %h want 001f", alu_x); end
    n_checks++; if (pc !== 15'd4) begin n_fail++; $display("FAIL add_pc: got %h want 4", pc); end
    run_instr(16'hE308);
    n_checks++; if (r_wr !== 1) begin n_fail++; $display("FAIL store_pulses: got %0d want 1", r_wr); end
    n_checks++; if (r_wdata !== 16'd31) begin n_fail++; $display("FAIL store_data: got %h want 001f", r_wdata); end
    n_checks++; if (r_waddr !== 15'd15) begin n_fail++; $display("FAIL store_addr: got %h want 000f", r_waddr); end
    n_checks++; if (write_m !== 1'b0) begin n_fail++; $display("FAIL store_deassert: got %b want 0", write_m); end
    n_checks++; if (pc !== 15'd5) begin n_fail++; $display("FAIL store_nojump_pc: got %h want 5", pc); end
  endtask

  task automatic test_jump;
    run_instr(16'hE301);
    n_checks++; if (pc !== 15'd15) begin n_fail++; $display("FAIL jgt_pc: got %h want f", pc); end
    run_instr(16'hE304);
    n_checks++; if (pc !== 15'd16) begin n_fail++; $display("FAIL jlt_pc: got %h want 10", pc); end
  endtask

  task automatic test_mem_read;
    run_instr(16'h0100);
    in_m = 16'h1234;
    run_instr(16'hFC10);
    n_checks++; if (r_ay !== 16'h1234) begin n_fail++; $display("FAIL mread_alu_y: got %h want 1234", r_ay); end
    n_checks++; if (alu_x !== 16'h1234) begin n_fail++; $display("FAIL mread_d: got %h want 1234", alu_x); end
    n_checks++; if (pc !== 15'd18) begin n_fail++; $display("FAIL mread_pc: got %h want 12", pc); end
  endtask

  task automatic test_reset_mid;
    instr = 16'hE308;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    n_checks++; if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b001100) begin n_fail++; $display("FAIL mid_in_exec: ctl got %b want 001100", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (address_m !== 15'd0 || alu_x !== 16'd0) begin n_fail++; $display("FAIL mid_a_d: got A=%h D=%h want 0 0", address_m, alu_x); end
    n_checks++; if (pc !== 15'd0 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pc_ready: got pc=%h rdy=%b want 0 0", pc, instr_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (write_m !== 1'b0) begin n_fail++; $display("FAIL mid_write_m: got %b want 0", write_m); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (write_m !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after: got wr=%b rdy=%b want 0 1", write_m, instr_ready); end
    in_m = 16'd0;
  endtask

  task automatic test_jump_with_a_write;
    run_instr(16'h0014);
    run_instr(16'hE327);
    n_checks++; if (pc !== 15'd20) begin n_fail++; $display("FAIL jmp_old_a_pc: got %h want 14", pc); end
    n_checks++; if (address_m !== 15'd0) begin n_fail++; $display("FAIL jmp_a_write: got %h want 0", address_m); end
  endtask

  task automatic test_pc_wrap;
    run_instr(16'h7FFF);
    run_instr(16'hEA87);
    n_checks++; if (pc !== 15'h7FFF) begin n_fail++; $display("FAIL wrap_setup_pc: got %h want 7fff", pc); end
    run_instr(16'h0005);
    n_checks++; if (pc !== 15'd0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc); end
    n_checks++; if (address_m !== 15'd5) begin n_fail++; $display("FAIL wrap_a: got %h want 5", address_m); end
  endtask

  task automatic test_self_jump;
    run_instr(16'h0004);
    run_instr(16'hEA87);
    run_instr(16'h0005);
    n_checks++; if (pc !== 15'd5) begin n_fail++; $display("FAIL self_setup_pc: got %h want 5", pc); end
    run_instr(16'hEA87);
`ifdef HACK_CTRL_HALT_EN
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
    instr = 16'h0001;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (instr_ready !== 1'b0 || pc !== 15'd5) begin n_fail++; $display("FAIL halt_idle: got rdy=%b pc=%h want 0 5", instr_ready, pc); end
    end
    instr_valid = 1'b0;
`else
    n_checks++; if (pc !== 15'd5 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL self_loop: got pc=%h rdy=%b want 5 1", pc, instr_ready); end
    run_instr(16'h0009);
    n_checks++; if (pc !== 15'd6 || address_m !== 15'd9) begin n_fail++; $display("FAIL self_continue: got pc=%h A=%h want 6 9", pc, address_m); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_a_instr();
    test_d_eq_a();
    test_add_store();
    test_jump();
    test_mem_read();
    test_reset_mid();
    test_jump_with_a_write();
    test_pc_wrap();
    test_self_jump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack control unit: the initiator that drives the 16-bit Hack ALU.
- Accepts one instruction per handshake and decodes A- and C-instructions. Drives the ALU operands and the six control bits (zx,nx,zy,ny,f,no), then consumes the ALU result and its zr/ng flags.
- Holds the A, D and PC registers, and drives the data-memory write port.

Parameters:
- RESET_PC, 15'd0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  16  instruction word for address pc.
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  block can accept an instruction.
- pc  out  15  address of the next instruction to fetch.
- in_m  in  16  data-memory read data at address_m.
- out_m  out  16  data-memory write data.
- write_m  out  1  data-memory write strobe, one cycle.
- address_m  out  15  data-memory address, equal to A[14:0].
- alu_x  out  16  ALU x operand.
- alu_y  out  16  ALU y operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits.
- alu_o  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- halted  out  1  halt indicator; exists only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous): A=0, D=0, PC=RESET_PC, state=FETCH, IR=0, result register=0, write_m=0, out_m=0, halted=0. instr_ready is 0 while rst_n is low.
- FSM states: FETCH, EXEC, WB.
- FETCH:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr into IR.
  - IR[15]=0 goes to WB; IR[15]=1 goes to EXEC.
  - With no valid, stay in FETCH; no register changes.
- EXEC:
  - alu_zx..alu_no = IR[11:6]; alu_x = D.
  - alu_y = IR[12] ? in_m : A.
  - Register alu_o into RES.
  - Evaluate jump: jmp = (IR[2]&alu_ng) | (IR[1]&alu_zr) | (IR[0]&~alu_ng&~alu_zr).
  - Next state WB.
- WB, A-instruction:
  - A <= {1'b0, IR[14:0]}.
  - PC <= PC+1.
- WB, C-instruction:
  - If IR[3]: write_m=1 for this cycle, out_m=RES, address_m = old A (before any A update this cycle).
  - If IR[4]: D <= RES.
  - If IR[5]: A <= RES.
  - PC <= jmp ? old A[14:0] : PC+1.
  - Next state FETCH.
- Instruction bits IR[14:13] of a C-instruction are ignored.
- ALU control outputs are driven only in EXEC and are 0 otherwise. alu_x and alu_y are driven continuously.
- in_m must be stable during EXEC.
- Latency: A-instruction 2 cycles, C-instruction 3 cycles, handshake cycle included. Maximum throughput is one instruction per 2 or 3 cycles.
- PC wraps from 15'h7FFF to 0.
- Jump with IR[2:0]=000 never jumps; 111 always jumps.
- Jump target uses A before this instruction's A write. This also applies when IR[5]=1 and a jump is taken in the same instruction.
- write_m is low in every state except WB of a C-instruction with IR[3]=1.
- Reset mid-instruction (EXEC or WB): the instruction is abandoned, with no partial writes to A, D, PC or memory.

Optional Feature:
- Macro: HACK_CTRL_HALT_EN.
- Defined:
  - In WB of a C-instruction with IR[2:0]=111, if old A[14:0] equals the address of the current instruction, set halted=1.
  - After halting, stay in an idle state with instr_ready=0; the FSM can no longer reach FETCH.
  - Only reset clears halted.
- Not defined: the halted port is absent and self-jumps loop normally.

Test Plan:
- Reset, then instr 0x0010 (@16) -> after 2 cycles A=16, pc=1, write_m never asserted.
- 0x0010 then 0xEC10 (D=A) -> during EXEC alu controls=110000 and alu_y=16; after WB D=16, pc=2.
- D=16, 0x000F then 0xE090 (D=D+A) -> D=31. Then 0xE308 (M=D) -> write_m high exactly 1 cycle in WB, out_m=31, address_m=15.
- D=31, A=15: 0xE301 (D;JGT) -> pc=15; 0xE304 (D;JLT) -> pc=old pc+1.
- A=0x0100, in_m=0x1234, 0xFC10 (D=M) -> alu_y=0x1234, D=0x1234. Assert rst_n low during EXEC of a following 0xE308 -> no write_m, A=D=0, pc=RESET_PC.
- HACK_CTRL_HALT_EN defined: @5 fetched at pc=4, then 0xEA87 (0;JMP) fetched at pc=5 -> halted=1, instr_ready stays 0 with instr_valid held high. With the macro undefined: pc returns to 5 and fetching continues.
